// File: rtl/dct_seq_pkg.sv
// dct_seq_pkg
//   Shared types and defaults for the DCT MAC sequencer.
//   dct_seq_state_t : sequencer FSM states (IDLE, ACCUM, DRAIN, HOLD)
//   DCT_TAPS_DEF    : default products accumulated per result
//   DCT_MAC_LAT_DEF : default MAC pipeline latency after the last mac_en
package dct_seq_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DRAIN,
        HOLD
    } dct_seq_state_t;

    localparam int unsigned DCT_TAPS_DEF    = 8;
    localparam int unsigned DCT_MAC_LAT_DEF = 2;

endpackage

// File: rtl/dct_seq_timeout.sv
// dct_seq_timeout
//   Sticky stall detector for the sequencer's HOLD state. The counter
//   advances on each enabled HOLD cycle with res_ready low, saturates at
//   2^TO_W-1, and clears whenever the sequencer is not in HOLD. The error
//   flag sets when the counter reaches its maximum and stays set until reset.
// Ports:
//   clk         : rising-edge clock
//   rst         : synchronous active-low reset
//   ena         : global clock enable
//   in_hold     : sequencer is in HOLD
//   res_ready   : downstream ready for the held result
//   timeout_err : sticky timeout flag (0 while rst is low)
module dct_seq_timeout #(
    parameter int unsigned TO_W = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic ena,
    input  logic in_hold,
    input  logic res_ready,
    output logic timeout_err
);

    logic [TO_W-1:0] cnt_q;
    logic            err_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else if (!in_hold) begin
            cnt_q <= '0;
        end else if (ena && !res_ready && cnt_q != '1) begin
            cnt_q <= cnt_q + TO_W'(1);
            // flag rises on the same edge the counter reaches its maximum
            if (cnt_q == {{(TO_W-1){1'b1}}, 1'b0})
                err_q <= 1'b1;
        end
    end

    assign timeout_err = rst & err_q;

endmodule

// File: rtl/dct_mac_sequencer.sv
// dct_mac_sequencer
//   Sequences one dct_unit MAC per coefficient request: TAPS product cycles
//   (ACCUM), MAC_LAT pipeline wait cycles (DRAIN) with a one-cycle result
//   capture pulse in the last, then holds the result under valid/ready (HOLD).
//   Optional feature macro: DCT_SEQ_TIMEOUT_EN adds a sticky HOLD-stall
//   timeout (port timeout_err, counter width TO_W).
// Ports:
//   clk, rst        : rising-edge clock, synchronous active-low reset
//   ena             : global clock enable; low freezes all state
//   start_valid/ready, row_sel : request handshake and row select
//   mac_clr, mac_en : MAC load / step controls
//   coef_addr       : {row_q, idx} coefficient ROM address
//   data_idx        : sample select (idx)
//   mac_cap         : one-cycle result register enable
//   res_valid/ready : result handshake
//   busy            : state is not IDLE
//   timeout_err     : sticky stall error (DCT_SEQ_TIMEOUT_EN only)
module dct_mac_sequencer
    import dct_seq_pkg::*;
#(
    parameter  int unsigned TAPS    = DCT_TAPS_DEF,
    parameter  int unsigned MAC_LAT = DCT_MAC_LAT_DEF,
    parameter  int unsigned TO_W    = 8,
    localparam int unsigned IDX_W   = $clog2(TAPS)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ena,
    input  logic               start_valid,
    output logic               start_ready,
    input  logic [2:0]         row_sel,
    output logic               mac_clr,
    output logic               mac_en,
    output logic [3+IDX_W-1:0] coef_addr,
    output logic [IDX_W-1:0]   data_idx,
    output logic               mac_cap,
    output logic               res_valid,
    input  logic               res_ready,
`ifdef DCT_SEQ_TIMEOUT_EN
    output logic               timeout_err,
`endif
    output logic               busy
);

    localparam int unsigned DCNT_W = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(TAPS - 1);
    localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(MAC_LAT - 1);

    dct_seq_state_t    state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [DCNT_W-1:0] dcnt_q, dcnt_d;
    logic [2:0]        row_q, row_d;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            dcnt_q  <= '0;
            row_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            dcnt_q  <= dcnt_d;
            row_q   <= row_d;
        end
    end

    // Outputs are gated by rst so they read 0 during the reset cycle even
    // though the state register only clears on the following edge.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        dcnt_d      = dcnt_q;
        row_d       = row_q;
        start_ready = ena & rst & ((state_q == IDLE) | ((state_q == HOLD) & res_ready));
        mac_en      = ena & rst & (state_q == ACCUM);
        mac_clr     = ena & rst & (state_q == ACCUM) & (idx_q == '0);
        mac_cap     = ena & rst & (state_q == DRAIN) & (dcnt_q == DCNT_LAST);
        res_valid   = rst & (state_q == HOLD);
        busy        = rst & (state_q != IDLE);
        coef_addr   = rst ? {row_q, idx_q} : '0;
        data_idx    = rst ? idx_q : '0;

        if (ena) begin
            unique case (state_q)
                IDLE: begin
                    if (start_valid) begin
                        state_d = ACCUM;
                        row_d   = row_sel;
                        idx_d   = '0;
                    end
                end
                ACCUM: begin
                    if (idx_q == IDX_LAST) begin
                        state_d = DRAIN;
                        idx_d   = '0;
                        dcnt_d  = '0;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
                DRAIN: begin
                    if (dcnt_q == DCNT_LAST)
                        state_d = HOLD;
                    else
                        dcnt_d = dcnt_q + DCNT_W'(1);
                end
                HOLD: begin
                    if (res_ready) begin
                        if (start_valid) begin
                            state_d = ACCUM;
                            row_d   = row_sel;
                            idx_d   = '0;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

`ifdef DCT_SEQ_TIMEOUT_EN
    dct_seq_timeout #(
        .TO_W (TO_W)
    ) u_timeout (
        .clk         (clk),
        .rst         (rst),
        .ena         (ena),
        .in_hold     (state_q == HOLD),
        .res_ready   (res_ready),
        .timeout_err (timeout_err)
    );
`endif

endmodule

// File: tb/tb_dct_mac_sequencer.sv
// tb_dct_mac_sequencer
//   Directed and randomized checks of dct_mac_sequencer against a reference
//   model that tracks progress as "cycles since accept". With the
//   DCT_SEQ_TIMEOUT_EN macro defined the timeout flag is checked as well.
module tb_dct_mac_sequencer;

    localparam int TAPS    = 8;
    localparam int MAC_LAT = 2;
    localparam int TO_W    = 4;
    localparam int DONE    = TAPS + MAC_LAT;
    localparam int TO_MAX  = (1 << TO_W) - 1;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       ena = 1'b0;
    logic       start_valid = 1'b0;
    logic       res_ready = 1'b0;
    logic [2:0] row_sel = 3'd0;
    logic       start_ready, mac_clr, mac_en, mac_cap, res_valid, busy;
    logic [5:0] coef_addr;
    logic [2:0] data_idx;
`ifdef DCT_SEQ_TIMEOUT_EN
    logic       timeout_err;
`endif

    dct_mac_sequencer #(
        .TAPS    (TAPS),
        .MAC_LAT (MAC_LAT),
        .TO_W    (TO_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .ena         (ena),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .row_sel     (row_sel),
        .mac_clr     (mac_clr),
        .mac_en      (mac_en),
        .coef_addr   (coef_addr),
        .data_idx    (data_idx),
        .mac_cap     (mac_cap),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
`ifdef DCT_SEQ_TIMEOUT_EN
        .timeout_err (timeout_err),
`endif
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // model: m_ph = -1 idle, 0..DONE-1 cycles since accept, DONE = result held
    int m_ph  = -1;
    int m_row = 0;
    int m_sc  = 0;
    bit m_err = 1'b0;

    int cyc = 0, acc_neg = -1, cap_neg = -1, rv_neg = -1, en_cnt = 0, cap_cnt = 0;
    bit prev_rv = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic step();
        bit r;
        bit rdy;
        int di;
        @(negedge clk);
        cyc++;
        r   = rst;
        rdy = ena && rst && (m_ph < 0 || (m_ph == DONE && res_ready));
        di  = (m_ph >= 0 && m_ph < TAPS) ? m_ph : 0;
        check("mac_en",      32'(mac_en),      32'(r && ena && m_ph >= 0 && m_ph < TAPS));
        check("mac_clr",     32'(mac_clr),     32'(r && ena && m_ph == 0));
        check("mac_cap",     32'(mac_cap),     32'(r && ena && m_ph == DONE - 1));
        check("res_valid",   32'(res_valid),   32'(r && m_ph == DONE));
        check("busy",        32'(busy),        32'(r && m_ph >= 0));
        check("start_ready", 32'(start_ready), 32'(rdy));
        check("data_idx",    32'(data_idx),    r ? 32'(di) : 32'd0);
        check("coef_addr",   32'(coef_addr),   r ? 32'(m_row * TAPS + di) : 32'd0);
`ifdef DCT_SEQ_TIMEOUT_EN
        check("timeout_err", 32'(timeout_err), 32'(r && m_err));
`endif
        if (start_valid && start_ready) begin
            acc_neg = cyc;
            en_cnt  = 0;
        end
        if (mac_en) en_cnt++;
        if (mac_cap) begin
            cap_neg = cyc;
            cap_cnt++;
        end
        if (res_valid && !prev_rv) rv_neg = cyc;
        prev_rv = res_valid;

        @(posedge clk);
        if (!rst) begin
            m_ph = -1; m_row = 0; m_sc = 0; m_err = 1'b0;
        end else if (ena) begin
            if (m_ph == DONE && !res_ready) begin
                if (m_sc < TO_MAX) begin
                    m_sc++;
                    if (m_sc == TO_MAX) m_err = 1'b1;
                end
            end else if (m_ph != DONE) begin
                m_sc = 0;
            end
            if (start_valid && rdy) begin
                m_ph  = 0;
                m_row = int'(row_sel);
            end else if (m_ph == DONE) begin
                if (res_ready) m_ph = -1;
            end else if (m_ph >= 0) begin
                m_ph++;
            end
        end
        #1;
    endtask

    task automatic wait_result(input string tag);
        for (int n = 0; n < 60 && rv_neg <= acc_neg; n++) step();
        check(tag, 32'(rv_neg > acc_neg), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int last_acc;
        int seen;
        int caps_before;

        // reset
        rst = 1'b0; ena = 1'b1;
        repeat (3) step();
        rst = 1'b1;
        step();

        // single request, row 5, then a 20-cycle output stall
        row_sel = 3'd5; start_valid = 1'b1; res_ready = 1'b0;
        step();
        start_valid = 1'b0; row_sel = 3'd2;
        wait_result("single_wait_rv");
        check("single_en_cnt",  32'(en_cnt), 32'd8);
        check("single_cap_lat", 32'(cap_neg - acc_neg), 32'(TAPS + MAC_LAT));
        check("single_rv_lat",  32'(rv_neg - acc_neg),  32'(TAPS + MAC_LAT + 1));
        repeat (20) step();
        check("stall_rv", 32'(res_valid), 32'd1);
        check("stall_sr", 32'(start_ready), 32'd0);
        res_ready = 1'b1;
        step();
        check("stall_release_idle", 32'(busy), 32'd0);

        // back-to-back accepts with row_sel changing every cycle
        start_valid = 1'b1; res_ready = 1'b1;
        last_acc = -1; seen = 0;
        for (int i = 0; i < 46; i++) begin
            row_sel = 3'($urandom);
            step();
            if (acc_neg != last_acc) begin
                if (seen > 0) check("b2b_spacing", 32'(acc_neg - last_acc), 32'(DONE + 1));
                last_acc = acc_neg;
                seen++;
            end
        end
        start_valid = 1'b0;
        for (int n = 0; n < 30 && busy !== 1'b0; n++) step();
        check("b2b_drain_idle", 32'(busy), 32'd0);

        // enable freeze for 3 cycles at idx 4
        row_sel = 3'd3; start_valid = 1'b1; res_ready = 1'b0;
        step();
        start_valid = 1'b0;
        for (int n = 0; n < 20 && !(mac_en === 1'b1 && data_idx == 3'd4); n++) step();
        check("freeze_at_idx4", 32'(data_idx), 32'd4);
        ena = 1'b0;
        repeat (3) step();
        ena = 1'b1;
        check("freeze_resume_idx", 32'(data_idx), 32'd4);
        wait_result("freeze_wait_rv");
        check("freeze_en_cnt", 32'(en_cnt), 32'd8);
        check("freeze_rv_lat", 32'(rv_neg - acc_neg), 32'(TAPS + MAC_LAT + 1 + 3));
        res_ready = 1'b1;
        step();

        // reset in the middle of ACCUM
        row_sel = 3'd6; start_valid = 1'b1; res_ready = 1'b0;
        step();
        start_valid = 1'b0;
        for (int n = 0; n < 20 && !(mac_en === 1'b1 && data_idx == 3'd3); n++) step();
        check("rst_at_idx3", 32'(data_idx), 32'd3);
        caps_before = cap_cnt;
        rst = 1'b0;
        step();
        rst = 1'b1;
        check("rst_idle", 32'(busy), 32'd0);
        repeat (4) step();
        check("rst_no_cap", 32'(cap_cnt), 32'(caps_before));
        row_sel = 3'd1; start_valid = 1'b1;
        step();
        start_valid = 1'b0;
        wait_result("after_rst_wait_rv");
        check("after_rst_rv_lat", 32'(rv_neg - acc_neg), 32'(TAPS + MAC_LAT + 1));
        res_ready = 1'b1;
        step();

`ifdef DCT_SEQ_TIMEOUT_EN
        // timeout: long HOLD stall, sticky through handshake, cleared by reset
        row_sel = 3'd7; start_valid = 1'b1; res_ready = 1'b0;
        step();
        start_valid = 1'b0;
        wait_result("to_wait_rv");
        repeat (20) step();
        check("to_set", 32'(timeout_err), 32'd1);
        res_ready = 1'b1;
        step();
        step();
        check("to_sticky", 32'(timeout_err), 32'd1);
        rst = 1'b0;
        step();
        rst = 1'b1;
        check("to_cleared", 32'(timeout_err), 32'd0);
        step();
`endif

        // randomized traffic
        for (int i = 0; i < 800; i++) begin
            ena         = ($urandom % 4) != 0;
            start_valid = ($urandom % 2) != 0;
            res_ready   = ($urandom % 3) != 0;
            row_sel     = 3'($urandom);
            rst         = ($urandom % 64) != 0;
            step();
        end
        rst = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dct_mac_sequencer.md
# dct_mac_sequencer

Sequencer for one DCT unit's multiply-accumulate datapath inside `fdct_zigzag.dct_mod`. Per coefficient request, it:
- steps the MAC through `TAPS` product cycles;
- waits out the MAC pipeline;
- pulses the capture enable of the `macu.result` register;
- presents the result under a valid/ready handshake.

One instance sits beside each `dct_unit` `macu`.

## Interface
Parameters:
- `TAPS`, default 8: products accumulated per result; `IDX_W = $clog2(TAPS)`.
- `MAC_LAT`, default 2: cycles from the last `mac_en` to the MAC output being stable. Legal range is 1 or more.
- `TO_W`, default 8: timeout counter width. Used only with `DCT_SEQ_TIMEOUT_EN`.

Ports:
- `clk`, input, 1: the only clock. All logic is rising-edge.
- `rst`, input, 1: synchronous, active-low reset.
- `ena`, input, 1: global clock enable. When low, all state freezes.
- `start_valid`, input, 1: coefficient request.
- `start_ready`, output, 1: request accepted when `start_valid & start_ready` on a rising edge.
- `row_sel`, input, 3: DCT row or coefficient set. Captured on acceptance.
- `mac_clr`, output, 1: MAC loads the product instead of accumulating.
- `mac_en`, output, 1: MAC step enable.
- `coef_addr`, output, 3+IDX_W: `{row_q, idx}`, the coefficient ROM address.
- `data_idx`, output, IDX_W: sample select, equal to `idx`.
- `mac_cap`, output, 1: one-cycle enable for the result register (the DFFE enable).
- `res_valid`, output, 1: result register holds a new value.
- `res_ready`, input, 1: downstream consumes the result.
- `busy`, output, 1: the state is not IDLE.
- `timeout_err`, output, 1: present only with `DCT_SEQ_TIMEOUT_EN`.

## Operation
States are IDLE, ACCUM, DRAIN and HOLD. Reset puts the block in IDLE.

Transitions:
- **IDLE → ACCUM** on accept. `row_q` is loaded and `idx` is set to 0.
- **ACCUM:**
  - `mac_en` is 1 in every ACCUM cycle; `mac_clr` is 1 only when `idx` is 0.
  - `idx` increments each cycle.
  - At `idx == TAPS-1`, go to DRAIN with `dcnt` set to 0.
- **DRAIN:**
  - `mac_en` is 0; `dcnt` increments each cycle.
  - `mac_cap` is 1 when `dcnt == MAC_LAT-1`; that cycle is also the transition to HOLD.
- **HOLD:** `res_valid` is 1.
  - If `res_ready` is 1 and `start_valid` is 1, go to ACCUM (back-to-back accept).
  - If `res_ready` is 1 and `start_valid` is 0, go to IDLE.
- `start_ready = ena & rst & (IDLE | (HOLD & res_ready))`. It is combinational and there is no other accept path.

`ena` low behaviour:
- `mac_en`, `mac_clr` and `mac_cap` are forced to 0.
- `start_ready` is 0 and `res_ready` is ignored.
- State, `idx`, `dcnt` and `row_q` hold.
- `res_valid` holds its value.

`row_sel` is sampled only on accept. Changes to `row_sel` while ACCUM is in progress have no effect.

`start_valid` rising while the block is busy is not lost: the request waits until `start_ready` is asserted.

## Timing
Reset behaviour:
- While `rst` is low at a clock edge, the next state is IDLE and `idx`, `dcnt` and `row_q` are 0.
- Outputs are 0 during reset: `mac_en`, `mac_clr`, `mac_cap`, `res_valid`, `busy`, `start_ready` and `timeout_err`.
- `coef_addr` and `data_idx` are 0 during reset.
- Reset mid-ACCUM or mid-DRAIN aborts the operation with no `mac_cap`. The following cycle is IDLE.

Cycle timing, for an accept at edge T with `ena` held high:
- ACCUM occupies cycles T+1 … T+TAPS.
- DRAIN occupies cycles T+TAPS+1 … T+TAPS+MAC_LAT.
- `mac_cap` is asserted in cycle T+TAPS+MAC_LAT.
- `res_valid` is asserted from cycle T+TAPS+MAC_LAT+1.
- With the defaults, `mac_cap` is asserted in cycle T+10 and `res_valid` from T+11.

Throughput and handshake rules:
- With back-to-back accepts in HOLD, one result is produced per TAPS+MAC_LAT+1 cycles.
- `res_valid` never deasserts without a handshake, except on reset.

## Configuration
Macro: `DCT_SEQ_TIMEOUT_EN`.
- **Defined:**
  - A TO_W-bit counter increments each `ena` cycle spent in HOLD with `res_ready` low, and clears on leaving HOLD.
  - When the counter reaches `2^TO_W-1`, `timeout_err` sets and stays set (sticky) until reset. The sequencer keeps holding and the result is not dropped.
- **Undefined:** the `timeout_err` port and the counter are absent. All other behaviour is identical.

## Structure
- Package `dct_seq_pkg`:
  - `dct_seq_state_t` enum (IDLE, ACCUM, DRAIN, HOLD);
  - `DCT_TAPS_DEF = 8`;
  - `DCT_MAC_LAT_DEF = 2`.
- Sub-module `dct_seq_timeout`: the sticky timeout counter, instantiated only under `DCT_SEQ_TIMEOUT_EN`.
- Everything else lives in the top module: the FSM, `idx`, `dcnt` and `row_q`.

## Test plan
- **Single request:** `row_sel=5`, accept at T with defaults → `mac_en` high T+1..T+8; `mac_clr` only at T+1; `coef_addr` 40..47; `mac_cap` at T+10; `res_valid` from T+11.
- **Stalled output:** hold `res_ready=0` for 20 cycles after `res_valid` → `res_valid` stays 1 and `start_ready` stays 0. Then `res_ready=1` with `start_valid=0` → IDLE on the next cycle.
- **Back-to-back:** `start_valid` and `res_ready` held 1 → accepts spaced 11 cycles apart; `mac_clr` precedes each run of 8 `mac_en`.
- **Enable freeze:** `ena=0` for 3 cycles at `idx=4` → no `mac_en` during the freeze; the run resumes at `idx=4`; `res_valid` is delayed by exactly 3 cycles.
- **Mid-ACCUM reset:** `rst=0` at `idx=3` → next cycle IDLE, all outputs 0, no `mac_cap`. A new request after reset completes normally.
- **Timeout** (macro defined, `TO_W=4`): `res_ready` held 0 → `timeout_err` rises after 15 HOLD cycles, stays 1 after the handshake, and clears only on reset.
